// File: rtl/slip_axis_decoder.sv
// SLIP (RFC 1055) decoder: raw UART byte stream in, framed AXI-Stream packets out.
// Bad escapes and over-length frames close the packet early and pulse frame_err.
`timescale 1ns/1ps
module slip_axis_decoder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_LEN    = 1500,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  frame_err,
  output logic [CNT_WIDTH-1:0]  frames_ok
);

  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [DATA_WIDTH-1:0] SYM_END     = DATA_WIDTH'(8'hC0);
  localparam logic [DATA_WIDTH-1:0] SYM_ESC     = DATA_WIDTH'(8'hDB);
  localparam logic [DATA_WIDTH-1:0] SYM_ESC_END = DATA_WIDTH'(8'hDC);
  localparam logic [DATA_WIDTH-1:0] SYM_ESC_ESC = DATA_WIDTH'(8'hDD);

  if (DATA_WIDTH != 8) begin : g_width_check
    $error("slip_axis_decoder: DATA_WIDTH must be 8");
  end

  typedef enum logic [1:0] {NORMAL, ESCAPE, DISCARD} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] pend;
  logic                  pend_valid;
  logic [LEN_W-1:0]      len;

  logic                  hs_c;
  logic                  dec_valid_c;
  logic [DATA_WIDTH-1:0] dec_byte_c;
  logic                  frame_end_c;
  logic                  esc_err_c;
  logic                  overflow_c;

  assign s_tready = !m_tvalid || m_tready;
  assign hs_c     = s_tvalid && s_tready;

  // Classify the accepted raw byte for the current state.
  always_comb begin
    dec_valid_c = 1'b0;
    dec_byte_c  = s_tdata;
    frame_end_c = 1'b0;
    esc_err_c   = 1'b0;
    if (hs_c) begin
      case (state)
        NORMAL: begin
          if (s_tdata == SYM_END)       frame_end_c = 1'b1;
          else if (s_tdata != SYM_ESC)  dec_valid_c = 1'b1;
        end
        ESCAPE: begin
          if (s_tdata == SYM_ESC_END) begin
            dec_valid_c = 1'b1;
            dec_byte_c  = SYM_END;
          end else if (s_tdata == SYM_ESC_ESC) begin
            dec_valid_c = 1'b1;
            dec_byte_c  = SYM_ESC;
          end else begin
            esc_err_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
    overflow_c = dec_valid_c && (len == LEN_W'(MAX_LEN));
  end

  // A handshake implies the output slot is free, so every load below is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= NORMAL;
      pend       <= '0;
      pend_valid <= 1'b0;
      len        <= '0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      frame_err  <= 1'b0;
      frames_ok  <= '0;
    end else begin
      frame_err <= 1'b0;
      if (m_tready) m_tvalid <= 1'b0;

      if (hs_c) begin
        case (state)
          NORMAL:  if (s_tdata == SYM_ESC) state <= ESCAPE;
          ESCAPE:  state <= (esc_err_c && s_tdata != SYM_END) ? DISCARD : NORMAL;
          DISCARD: if (s_tdata == SYM_END) state <= NORMAL;
          default: state <= NORMAL;
        endcase
      end

      if (frame_end_c && pend_valid) begin
        m_tdata    <= pend;
        m_tlast    <= 1'b1;
        m_tvalid   <= 1'b1;
        pend_valid <= 1'b0;
        len        <= '0;
        frames_ok  <= frames_ok + CNT_WIDTH'(1);
      end

      if (esc_err_c || overflow_c) begin
        if (pend_valid) begin
          m_tdata  <= pend;
          m_tlast  <= 1'b1;
          m_tvalid <= 1'b1;
        end
        frame_err  <= 1'b1;
        pend_valid <= 1'b0;
        len        <= '0;
        if (overflow_c) state <= DISCARD;
      end else if (dec_valid_c) begin
        if (pend_valid) begin
          m_tdata  <= pend;
          m_tlast  <= 1'b0;
          m_tvalid <= 1'b1;
        end
        pend       <= dec_byte_c;
        pend_valid <= 1'b1;
        len        <= len + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_slip_axis_decoder.sv
// Testbench for slip_axis_decoder: directed vector table, length boundary,
// randomized backpressure against a scoreboard, and mid-frame reset.
`timescale 1ns/1ps
module tb_slip_axis_decoder;

  localparam int unsigned MAXL = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic        m_tlast;
  logic        frame_err;
  logic [15:0] frames_ok;

  slip_axis_decoder #(.DATA_WIDTH(8), .MAX_LEN(MAXL), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .frame_err(frame_err), .frames_ok(frames_ok)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         err_pulses = 0;
  int         exp_frames = 0;
  logic [8:0] got[$];
  logic [8:0] expq[$];
  bit         rnd_ready = 1'b0;
  bit         prev_stall = 1'b0;
  logic [8:0] prev_out = '0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: collects transfers, counts error pulses, checks hold under stall.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall)
        check("hold_stable", int'({m_tvalid, m_tlast, m_tdata}), int'({1'b1, prev_out}));
      if (m_tvalid && m_tready) got.push_back({m_tlast, m_tdata});
      if (frame_err) err_pulses++;
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tlast, m_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      m_tready = ($urandom_range(0, 99) >= 30);
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: s_tready stuck low for byte 0x%0h", b);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_slip(input logic [7:0] b);
    if (b == 8'hC0) begin send(8'hDB); send(8'hDC); end
    else if (b == 8'hDB) begin send(8'hDB); send(8'hDD); end
    else send(b);
  endtask

  task automatic drain(input int n_exp);
    int n = 0;
    while (got.size() < n_exp && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       name;
    logic [63:0] in_bytes;
    int          n_in;
    logic [35:0] exp_out;
    int          n_exp;
    int          d_frames;
    int          n_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int e0;
    int len;
    logic [7:0] b;
    logic [8:0] e;

    vecs[0] = '{"basic",     64'hC0010203C0000000, 5, {9'h001, 9'h002, 9'h103, 9'h000}, 3, 1, 0};
    vecs[1] = '{"escapes",   64'h05DBDCDBDDC00000, 6, {9'h005, 9'h0C0, 9'h1DB, 9'h000}, 3, 1, 0};
    vecs[2] = '{"empty",     64'hC0C0C0AAC0000000, 5, {9'h1AA, 27'h0},                  1, 1, 0};
    vecs[3] = '{"bad_esc",   64'h1122DB4133C044C0, 8, {9'h011, 9'h122, 9'h144, 9'h000}, 3, 1, 1};
    vecs[4] = '{"bad_esc_end", 64'h55DBC066C0000000, 5, {9'h155, 9'h166, 18'h0},        2, 1, 1};
    vecs[5] = '{"esc_first", 64'hDBDCC00000000000, 3, {9'h1C0, 27'h0},                  1, 1, 0};
    vecs[6] = '{"bad_no_pend", 64'hDB77C00000000000, 3, 36'h0,                          0, 0, 1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", int'(m_tvalid), 0);
    check("rst_m_tdata", int'(m_tdata), 0);
    check("rst_m_tlast", int'(m_tlast), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_frames_ok", int'(frames_ok), 0);
    check("rst_s_tready", int'(s_tready), 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vector table with m_tready held high.
    foreach (vecs[v]) begin
      got.delete();
      e0 = err_pulses;
      for (int i = 0; i < vecs[v].n_in; i++) send(vecs[v].in_bytes[63 - 8*i -: 8]);
      drain(vecs[v].n_exp);
      check($sformatf("%s_count", vecs[v].name), got.size(), vecs[v].n_exp);
      for (int i = 0; i < vecs[v].n_exp; i++) begin
        e = vecs[v].exp_out[35 - 9*i -: 9];
        if (i < got.size()) check($sformatf("%s_out%0d", vecs[v].name, i), int'(got[i]), int'(e));
      end
      exp_frames += vecs[v].d_frames;
      check($sformatf("%s_frames_ok", vecs[v].name), int'(frames_ok), exp_frames);
      check($sformatf("%s_err_pulses", vecs[v].name), err_pulses - e0, vecs[v].n_err);
    end

    // Length boundary: MAXL+1 bytes overflows, exactly MAXL bytes is good.
    for (int k = 0; k < 2; k++) begin
      len = (k == 0) ? MAXL + 1 : MAXL;
      got.delete();
      e0 = err_pulses;
      for (int i = 1; i <= len; i++) send(8'(i));
      send(8'hC0);
      drain(MAXL);
      check($sformatf("len%0d_count", len), got.size(), MAXL);
      for (int i = 0; i < got.size() && i < MAXL; i++)
        check($sformatf("len%0d_out%0d", len, i), int'(got[i]),
              int'({(i == MAXL - 1) ? 1'b1 : 1'b0, 8'(i + 1)}));
      if (k == 1) exp_frames++;
      check($sformatf("len%0d_frames_ok", len), int'(frames_ok), exp_frames);
      check($sformatf("len%0d_err_pulses", len), err_pulses - e0, (k == 0) ? 1 : 0);
    end

    // Random frames under random backpressure against a scoreboard.
    got.delete();
    expq.delete();
    e0 = err_pulses;
    rnd_ready = 1'b1;
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, 64);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        expq.push_back({(i == len - 1) ? 1'b1 : 1'b0, b});
        send_slip(b);
      end
      send(8'hC0);
    end
    drain(expq.size());
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    m_tready = 1'b1;
    exp_frames += 200;
    check("rand_count", got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++) begin
      check($sformatf("rand_out%0d", i), int'(got[i]), int'(expq[i]));
      if (got[i] != expq[i]) break;
    end
    check("rand_frames_ok", int'(frames_ok), exp_frames);
    check("rand_err_pulses", err_pulses - e0, 0);

    // Reset mid-frame while an output is stalled.
    m_tready = 1'b0;
    send(8'h01);
    send(8'h02);
    repeat (2) @(posedge clk);
    #3;
    check("pre_reset_m_tvalid", int'(m_tvalid), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_m_tvalid", int'(m_tvalid), 0);
    check("async_reset_frames_ok", int'(frames_ok), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_tready = 1'b1;
    got.delete();
    e0 = err_pulses;
    @(posedge clk);
    #1;
    send(8'hC0);
    send(8'h10);
    send(8'h20);
    send(8'hC0);
    drain(2);
    check("post_reset_count", got.size(), 2);
    if (got.size() >= 2) begin
      check("post_reset_out0", int'(got[0]), int'(9'h010));
      check("post_reset_out1", int'(got[1]), int'(9'h120));
    end
    check("post_reset_frames_ok", int'(frames_ok), 1);
    check("post_reset_err_pulses", err_pulses - e0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
